// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, writeback.
// Build macro RV_CTRL_SYSTEM_EN: opcode 1110011 halts the core instead of trapping as illegal.
module rv_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       instr_20,
    input  logic       br_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] alu_fn,
    output logic       alu_alt,
    output logic       illegal,
    output logic       fault,
    output logic       halted,
    output logic [2:0] state_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] CL_R       = 4'd0;
    localparam logic [3:0] CL_IMM     = 4'd1;
    localparam logic [3:0] CL_LOAD    = 4'd2;
    localparam logic [3:0] CL_STORE   = 4'd3;
    localparam logic [3:0] CL_LUI     = 4'd4;
    localparam logic [3:0] CL_AUIPC   = 4'd5;
    localparam logic [3:0] CL_JAL     = 4'd6;
    localparam logic [3:0] CL_JALR    = 4'd7;
    localparam logic [3:0] CL_BRANCH  = 4'd8;
    localparam logic [3:0] CL_ILLEGAL = 4'd10;
`ifdef RV_CTRL_SYSTEM_EN
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [3:0] CL_SYSTEM  = 4'd9;
`endif

    function automatic logic [3:0] classify(input logic [6:0] op);
        logic [3:0] cl;
        case (op)
            OP_R:      cl = CL_R;
            OP_IMM:    cl = CL_IMM;
            OP_LOAD:   cl = CL_LOAD;
            OP_STORE:  cl = CL_STORE;
            OP_LUI:    cl = CL_LUI;
            OP_AUIPC:  cl = CL_AUIPC;
            OP_JAL:    cl = CL_JAL;
            OP_JALR:   cl = CL_JALR;
            OP_BRANCH: cl = CL_BRANCH;
`ifdef RV_CTRL_SYSTEM_EN
            OP_SYSTEM: cl = CL_SYSTEM;
`endif
            default:   cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [3:0]    class_r;
    logic [3:0]    decoded_cl_s;
    logic [TW-1:0] wait_cnt_r;
    logic          timeout_s;
    logic          mem_timeout_s;
    logic          illegal_r;
    logic          fault_r;
    logic          unused_instr20_s;

    // ECALL vs EBREAK only matters to an external trace; the sequencing treats them alike.
    assign unused_instr20_s = instr_20;
    assign decoded_cl_s     = classify(opcode);
    assign timeout_s        = (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    assign mem_timeout_s    = timeout_s &&
                              (((state_r == ST_FETCH) && !imem_ack) ||
                               ((state_r == ST_MEM) && !dmem_ack));

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT:   state_nxt_s = ST_FETCH;
            ST_FETCH:  state_nxt_s = imem_ack ? ST_DECODE : (timeout_s ? ST_TRAP : ST_FETCH);
            ST_DECODE: begin
                case (decoded_cl_s)
                    CL_ILLEGAL: state_nxt_s = ST_TRAP;
`ifdef RV_CTRL_SYSTEM_EN
                    CL_SYSTEM:  state_nxt_s = ST_HALT;
`endif
                    default:    state_nxt_s = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (class_r)
                    CL_LOAD, CL_STORE:          state_nxt_s = ST_MEM;
                    CL_JAL, CL_JALR, CL_BRANCH: state_nxt_s = ST_FETCH;
                    default:                    state_nxt_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_nxt_s = (class_r == CL_STORE) ? ST_FETCH : ST_WB;
                end else begin
                    state_nxt_s = timeout_s ? ST_TRAP : ST_MEM;
                end
            end
            ST_WB:            state_nxt_s = ST_FETCH;
            ST_TRAP, ST_HALT: state_nxt_s = state_r;
            default:          state_nxt_s = ST_TRAP;
        endcase
    end

    // State, latched instruction class and ack wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            class_r    <= CL_R;
            wait_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_DECODE) begin
                class_r <= decoded_cl_s;
            end
            if (state_nxt_s != state_r) begin
                wait_cnt_r <= '0;
            end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
                wait_cnt_r <= wait_cnt_r + TW'(1);
            end
        end
    end

    // Sticky status flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            if ((state_r == ST_DECODE) && (decoded_cl_s == CL_ILLEGAL)) begin
                illegal_r <= 1'b1;
            end
            if (mem_timeout_s) begin
                fault_r <= 1'b1;
            end
        end
    end

`ifdef RV_CTRL_SYSTEM_EN
    logic halted_r;

    // Halt flag for ECALL/EBREAK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else if ((state_r == ST_DECODE) && (decoded_cl_s == CL_SYSTEM)) begin
            halted_r <= 1'b1;
        end
    end
    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    assign illegal = illegal_r;
    assign fault   = fault_r;
    assign state_o = state_r;

    // Datapath controls decoded from the current state; acks and br_taken act within the cycle
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_fn    = 3'd0;
        alu_alt   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            ST_EXEC: begin
                case (class_r)
                    CL_R: begin
                        alu_fn  = funct3;
                        alu_alt = funct7_5;
                    end
                    CL_IMM: begin
                        alu_b_sel = 1'b1;
                        alu_fn    = funct3;
                        alu_alt   = (funct3 == 3'b101) ? funct7_5 : 1'b0;
                    end
                    CL_LOAD, CL_STORE: alu_b_sel = 1'b1;
                    CL_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    CL_JAL: begin
                        rf_we  = 1'b1;
                        wb_sel = 2'd2;
                        pc_we  = 1'b1;
                        pc_sel = 2'd1;
                    end
                    CL_JALR: begin
                        alu_b_sel = 1'b1;
                        rf_we     = 1'b1;
                        wb_sel    = 2'd2;
                        pc_we     = 1'b1;
                        pc_sel    = 2'd2;
                    end
                    CL_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? 2'd1 : 2'd0;
                    end
                    default: alu_fn = 3'd0;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_r == CL_STORE);
                pc_we    = dmem_ack && (class_r == CL_STORE);
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (class_r == CL_LOAD) ? 2'd1 : ((class_r == CL_LUI) ? 2'd3 : 2'd0);
            end
            default: imem_req = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle control trace, checked every cycle, plus hand-computed pins.
module tb_rv_multicycle_ctrl;
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [2:0] alu_fn;
        logic       alu_alt;
        logic       illegal;
        logic       fault;
        logic       halted;
        logic [2:0] state;
    } ctl_t;

    typedef struct {
        string name;
        int    act;
        int    req;
    } pin_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       instr_20 = 1'b0;
    logic       br_taken = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic       alu_a_sel, alu_b_sel, alu_alt, illegal, fault, halted;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] alu_fn, state_o;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .instr_20(instr_20), .br_taken(br_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_fn(alu_fn), .alu_alt(alu_alt),
        .illegal(illegal), .fault(fault), .halted(halted), .state_o(state_o)
    );

    always #5 clk = ~clk;

    ctl_t act_s;
    assign act_s = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                    alu_a_sel, alu_b_sel, alu_fn, alu_alt, illegal, fault, halted, state_o};

    ctl_t exp_q[$];
    pin_t pin_q[$];
    int   exp_rd = 0;
    int   pin_rd = 0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pcwe_cnt = 0;
    logic m_illegal = 1'b0;
    logic m_fault = 1'b0;
    logic m_halted = 1'b0;

    // Single compare process: one trace record per cycle, then any pending pinned literals
    always @(negedge clk or negedge rst_n) begin
        #1;
        if (exp_rd < exp_q.size()) begin
            checks = checks + 1;
            if (act_s !== exp_q[exp_rd]) begin
                failures = failures + 1;
                $display("FAIL trace[%0d] t=%0t state=%0d actual=%h required=%h",
                         exp_rd, $time, state_o, act_s, exp_q[exp_rd]);
            end
            exp_rd = exp_rd + 1;
        end
        while (pin_rd < pin_q.size()) begin
            checks = checks + 1;
            if (pin_q[pin_rd].act != pin_q[pin_rd].req) begin
                failures = failures + 1;
                $display("FAIL %s actual=%0d required=%0d",
                         pin_q[pin_rd].name, pin_q[pin_rd].act, pin_q[pin_rd].req);
            end
            pin_rd = pin_rd + 1;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && pc_we) pcwe_cnt = pcwe_cnt + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic ctl_t rec(input logic [2:0] st);
        ctl_t e;
        e = '0;
        e.state   = st;
        e.illegal = m_illegal;
        e.fault   = m_fault;
        e.halted  = m_halted;
        return e;
    endfunction

    task automatic cycle(input ctl_t e, input logic ia, input logic da, input logic bt);
        @(posedge clk);
        #1;
        imem_ack = ia;
        dmem_ack = da;
        br_taken = bt;
        exp_q.push_back(e);
    endtask

    task automatic pin(input string name, input int act, input int req);
        pin_t p;
        p.name = name;
        p.act  = act;
        p.req  = req;
        pin_q.push_back(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        m_illegal = 1'b0;
        m_fault   = 1'b0;
        m_halted  = 1'b0;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        exp_q.push_back(rec(3'd0));
        rst_n = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // fw/mw: cycles without ack before the acking cycle; noise: stray acks where no request is up
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                             input logic br, input logic nz);
        ctl_t e;
        logic st;
        opcode = w[6:0]; funct3 = w[14:12]; funct7_5 = w[30]; instr_20 = w[20];
        for (int i = 0; i < fw; i++) begin
            e = rec(3'd1); e.imem_req = 1'b1; cycle(e, 1'b0, nz, br);
        end
        e = rec(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1; cycle(e, 1'b1, nz, br);
        cycle(rec(3'd2), nz, nz, br);
        case (w[6:0])
            7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111: begin
                e = rec(3'd3);
                if (w[6:0] == 7'b0110011) begin
                    e.alu_fn = w[14:12]; e.alu_alt = w[30];
                end else if (w[6:0] == 7'b0010011) begin
                    e.alu_b_sel = 1'b1; e.alu_fn = w[14:12];
                    e.alu_alt = (w[14:12] == 3'b101) && w[30];
                end else if (w[6:0] == 7'b0010111) begin
                    e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1;
                end
                cycle(e, nz, nz, br);
                e = rec(3'd5); e.rf_we = 1'b1; e.pc_we = 1'b1;
                e.wb_sel = (w[6:0] == 7'b0110111) ? 2'd3 : 2'd0;
                cycle(e, nz, nz, br);
            end
            7'b0000011, 7'b0100011: begin
                st = (w[6:0] == 7'b0100011);
                e = rec(3'd3); e.alu_b_sel = 1'b1; cycle(e, nz, nz, br);
                for (int i = 0; i < mw; i++) begin
                    e = rec(3'd4); e.dmem_req = 1'b1; e.dmem_we = st; cycle(e, nz, 1'b0, br);
                end
                e = rec(3'd4); e.dmem_req = 1'b1; e.dmem_we = st; e.pc_we = st;
                cycle(e, nz, 1'b1, br);
                if (!st) begin
                    e = rec(3'd5); e.rf_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = 2'd1;
                    cycle(e, nz, nz, br);
                end
            end
            7'b1101111: begin
                e = rec(3'd3); e.rf_we = 1'b1; e.wb_sel = 2'd2; e.pc_we = 1'b1; e.pc_sel = 2'd1;
                cycle(e, nz, nz, br);
            end
            7'b1100111: begin
                e = rec(3'd3); e.alu_b_sel = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'd2;
                e.pc_we = 1'b1; e.pc_sel = 2'd2;
                cycle(e, nz, nz, br);
            end
            7'b1100011: begin
                e = rec(3'd3); e.pc_we = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0;
                cycle(e, nz, nz, br);
            end
`ifdef RV_CTRL_SYSTEM_EN
            7'b1110011: begin
                m_halted = 1'b1;
                cycle(rec(3'd7), nz, nz, br);
                cycle(rec(3'd7), nz, nz, br);
            end
`endif
            default: begin
                m_illegal = 1'b1;
                cycle(rec(3'd6), nz, nz, br);
                cycle(rec(3'd6), nz, nz, br);
            end
        endcase
    endtask

    task automatic pin_instr(input string name, input logic [31:0] w, input int fw, input int mw,
                             input logic br, input logic nz, input int ncyc, input int npc);
        int c0;
        int p0;
        c0 = cyc;
        p0 = pcwe_cnt;
        run_instr(w, fw, mw, br, nz);
        @(negedge clk);
        #2;
        pin({name, "_cycles"}, cyc - c0, ncyc);
        pin({name, "_pc_we"}, pcwe_cnt - p0, npc);
    endtask

    task automatic run_fetch_timeout();
        ctl_t e;
        opcode = 7'b0110011;
        for (int i = 0; i < 4; i++) begin
            e = rec(3'd1); e.imem_req = 1'b1; cycle(e, 1'b0, 1'b1, 1'b0);
        end
        m_fault = 1'b1;
        cycle(rec(3'd6), 1'b1, 1'b1, 1'b0);
        cycle(rec(3'd6), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        pin("timeout_fault", int'(fault), 1);
        pin("timeout_state", int'(state_o), 6);
    endtask

    task automatic run_load_reset();
        ctl_t e;
        opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        e = rec(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1; cycle(e, 1'b1, 1'b0, 1'b0);
        cycle(rec(3'd2), 1'b0, 1'b0, 1'b0);
        e = rec(3'd3); e.alu_b_sel = 1'b1; cycle(e, 1'b0, 1'b0, 1'b0);
        e = rec(3'd4); e.dmem_req = 1'b1; cycle(e, 1'b0, 1'b0, 1'b0);
        do_reset();
    endtask

    initial begin
        do_reset();
        pin_instr("add",   32'h002081B3, 0, 0, 1'b0, 1'b0, 4, 1);
        pin_instr("sub",   32'h402081B3, 0, 0, 1'b0, 1'b1, 4, 1);
        pin_instr("srai",  32'h4030D293, 0, 0, 1'b0, 1'b0, 4, 1);
        pin_instr("srli",  32'h0030D293, 0, 0, 1'b0, 1'b1, 4, 1);
        pin_instr("addin", 32'hC0008093, 0, 0, 1'b0, 1'b0, 4, 1);
        pin_instr("add_w3", 32'h002081B3, 3, 0, 1'b0, 1'b1, 7, 1);
        pin_instr("lw",    32'h0000A283, 0, 2, 1'b0, 1'b1, 7, 1);
        pin_instr("sw",    32'h0050A023, 0, 0, 1'b0, 1'b0, 4, 1);
        pin_instr("sw_w3", 32'h0050A023, 0, 3, 1'b0, 1'b1, 7, 1);
        pin_instr("beq_t", 32'h00208463, 0, 0, 1'b1, 1'b0, 3, 1);
        pin_instr("beq_n", 32'h00208463, 0, 0, 1'b0, 1'b1, 3, 1);
        pin_instr("jal",   32'h008000EF, 0, 0, 1'b0, 1'b0, 3, 1);
        pin_instr("jalr",  32'h000080E7, 0, 0, 1'b0, 1'b1, 3, 1);
        pin_instr("lui",   32'h123452B7, 0, 0, 1'b0, 1'b0, 4, 1);
        pin_instr("auipc", 32'h00001297, 0, 0, 1'b0, 1'b0, 4, 1);
        run_load_reset();
        pin_instr("add_rst", 32'h002081B3, 0, 0, 1'b0, 1'b0, 4, 1);
        run_fetch_timeout();
        do_reset();
        pin_instr("ecall", 32'h00000073, 0, 0, 1'b0, 1'b1, 4, 0);
`ifdef RV_CTRL_SYSTEM_EN
        pin("ecall_halted", int'(halted), 1);
`else
        pin("ecall_illegal", int'(illegal), 1);
`endif
        do_reset();
        pin_instr("op7f", 32'h0000007F, 0, 0, 1'b0, 1'b1, 4, 0);
        pin("op7f_illegal", int'(illegal), 1);
        do_reset();
        pin_instr("add_end", 32'h002081B3, 1, 0, 1'b0, 1'b0, 5, 1);
        repeat (3) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
